ddr3_byte_packer: RTL and testbench

//  Consumes the 288-bit {data[255:0], byte_valid[31:0]} word stream from the DDR3 read FIFO.

---
 rtl/ddr3_byte_packer.sv | 231 +++++++++++++++++++++++
 tb/tb_ddr3_byte_packer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_byte_packer.sv
// ddr3_byte_packer
//   Takes {data[255:0], byte_valid[31:0]} words from the DDR3 read FIFO. It drops the bytes whose
//   valid bit is clear and packs the remaining bytes, in address order, into a byte buffer. The
//   buffer is emitted as dense OUT_BYTES-wide words on a valid/ready stream with keep and last.
//
// Ports
//   ddr3_emif_clk / ddr3_emif_rst    clock, synchronous active-high reset
//   xfer_start, xfer_byte_num        start pulse and payload byte count of a transfer
//   busy, xfer_done, overflow_err    transfer status; overflow_err is sticky until reset
//   fifo_data_ready_in               FIFO not empty
//   fifo_read_req_out                single-cycle pop request, at most one outstanding
//   fifo_read_data_in/_valid_in      popped word, valid one cycle after the request
//   out_data/out_keep/out_valid/     packed output stream, byte 0 in the MSB lane
//   out_ready/out_last
//
// The byte_valid mask is expected to be one contiguous run of ones, or all zero. CNT_W must be at
// least 6.

module ddr3_byte_packer #(
  parameter int unsigned OUT_BYTES = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                   ddr3_emif_clk,
  input  logic                   ddr3_emif_rst,
  input  logic                   xfer_start,
  input  logic [CNT_W-1:0]       xfer_byte_num,
  output logic                   busy,
  output logic                   xfer_done,
  output logic                   overflow_err,
  input  logic                   fifo_data_ready_in,
  output logic                   fifo_read_req_out,
  input  logic [287:0]           fifo_read_data_in,
  input  logic                   fifo_read_data_valid_in,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  // A fetch is only issued with fewer than OUT_BYTES bytes held, so one appended input word can
  // raise the buffer to at most 32 + OUT_BYTES - 1 bytes.
  localparam int unsigned   BUF_N  = 32 + OUT_BYTES - 1;
  localparam int unsigned   CW     = $clog2(BUF_N + 1);
  localparam logic [CW-1:0] OB_CNT = CW'(OUT_BYTES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // State
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_left;
  logic [CW-1:0]    r_buf_cnt;
  logic [7:0]       r_buf [BUF_N];
  logic             r_ovf;

  // Next state
  logic [1:0]       w_state_d;
  logic [CNT_W-1:0] w_left_d;
  logic [CW-1:0]    w_buf_cnt_d;
  logic [7:0]       w_buf_d [BUF_N];
  logic             w_ovf_d;

  // Input decode and compaction
  logic [7:0]       w_in_byte [32];
  logic [31:0]      w_in_vld;
  logic [5:0]       w_vcnt;
  logic [5:0]       w_app;
  logic             w_ovf_now;
  logic [7:0]       w_comp [32];
  logic [5:0]       w_k;

  // Buffer update
  logic [7:0]       w_shf [BUF_N];
  logic [CW-1:0]    w_base;
  logic [CW-1:0]    w_end;
  logic [4:0]       w_idx;

  // Control
  logic             w_run;
  logic             w_full;
  logic             w_tail;
  logic             w_hs;
  logic             w_app_en;
  logic [OUT_BYTES-1:0] w_keep;

  // Input byte i sits at data[255-8i -: 8]; its valid bit is byte_valid[31-i].
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_in_byte[i] = fifo_read_data_in[287-8*i -: 8];
      w_in_vld[i]  = fifo_read_data_in[31-i];
    end
  end

  always_comb begin
    w_vcnt = '0;
    for (int i = 0; i < 32; i++) begin
      w_vcnt = w_vcnt + {5'd0, w_in_vld[i]};
    end
  end

  // Bytes beyond the remaining transfer length are dropped and flagged.
  assign w_ovf_now = CNT_W'(w_vcnt) > r_left;
  assign w_app     = w_ovf_now ? r_left[5:0] : w_vcnt;

  // Gather the first w_app valid bytes into w_comp[0..w_app-1].
  always_comb begin
    w_k = '0;
    for (int i = 0; i < 32; i++) begin
      w_comp[i] = 8'h00;
    end
    for (int i = 0; i < 32; i++) begin
      if (w_in_vld[i] && (w_k < w_app)) begin
        w_comp[w_k[4:0]] = w_in_byte[i];
        w_k              = w_k + 6'd1;
      end
    end
  end

  // Output side
  assign w_run     = (r_state == ST_FETCH) || (r_state == ST_WAIT);
  assign w_full    = r_buf_cnt >= OB_CNT;
  assign w_tail    = (r_left == '0) && (r_buf_cnt != '0) && !w_full;
  assign out_valid = w_run && (w_full || w_tail);
  assign out_last  = out_valid && (r_left == '0) && (r_buf_cnt <= OB_CNT);
  assign w_hs      = out_valid && out_ready;

  always_comb begin
    for (int j = 0; j < OUT_BYTES; j++) begin
      w_keep[OUT_BYTES-1-j]              = out_valid && (CW'(j) < r_buf_cnt);
      out_data[8*(OUT_BYTES-1-j) +: 8]   = w_keep[OUT_BYTES-1-j] ? r_buf[j] : 8'h00;
    end
  end
  assign out_keep = w_keep;

  assign busy              = w_run;
  assign xfer_done         = (r_state == ST_DONE);
  assign overflow_err      = r_ovf;
  assign fifo_read_req_out = (r_state == ST_FETCH) && fifo_data_ready_in && !w_full &&
                             (r_left != '0);
  assign w_app_en          = (r_state == ST_WAIT) && fifo_read_data_valid_in;

  // Buffer contents after a handshake, before any append.
  always_comb begin
    for (int j = 0; j < BUF_N; j++) begin
      w_shf[j] = 8'h00;
    end
    for (int j = 0; j < BUF_N - OUT_BYTES; j++) begin
      w_shf[j] = r_buf[j+OUT_BYTES];
    end
  end

  // A partial final word empties the buffer rather than removing a full OUT_BYTES.
  assign w_base = r_buf_cnt - (w_hs ? (w_full ? OB_CNT : r_buf_cnt) : '0);
  assign w_end  = w_base + CW'(w_app);

  // Kept bytes fill [0, w_base); appended bytes fill [w_base, w_end); everything above is zero.
  always_comb begin
    w_idx = '0;
    for (int j = 0; j < BUF_N; j++) begin
      w_buf_d[j] = 8'h00;
      w_idx      = 5'(j) - w_base[4:0];
      if (CW'(j) < w_base) begin
        w_buf_d[j] = w_hs ? w_shf[j] : r_buf[j];
      end else if (w_app_en && (CW'(j) < w_end)) begin
        w_buf_d[j] = w_comp[w_idx];
      end
    end
  end

  assign w_buf_cnt_d = w_app_en ? w_end : w_base;

  always_comb begin
    w_state_d = r_state;
    w_left_d  = r_left;
    w_ovf_d   = r_ovf;
    if (w_app_en) begin
      w_left_d = r_left - CNT_W'(w_app);
      if (w_ovf_now) begin
        w_ovf_d = 1'b1;
      end
    end
    case (r_state)
      ST_IDLE: begin
        if (xfer_start) begin
          w_left_d  = xfer_byte_num;
          w_state_d = (xfer_byte_num == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fifo_read_req_out) begin
          w_state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fifo_read_data_valid_in) begin
          w_state_d = ST_FETCH;
        end
      end
      ST_DONE:  w_state_d = ST_IDLE;
      default:  w_state_d = ST_IDLE;
    endcase
    // The handshake that drains the last byte ends the transfer.
    if (w_hs && (w_left_d == '0) && (w_buf_cnt_d == '0)) begin
      w_state_d = ST_DONE;
    end
  end

  always_ff @(posedge ddr3_emif_clk) begin
    if (ddr3_emif_rst) begin
      r_state   <= ST_IDLE;
      r_left    <= '0;
      r_buf_cnt <= '0;
      r_ovf     <= 1'b0;
      for (int j = 0; j < BUF_N; j++) begin
        r_buf[j] <= 8'h00;
      end
    end else begin
      r_state   <= w_state_d;
      r_left    <= w_left_d;
      r_buf_cnt <= w_buf_cnt_d;
      r_ovf     <= w_ovf_d;
      for (int j = 0; j < BUF_N; j++) begin
        r_buf[j] <= w_buf_d[j];
      end
    end
  end

endmodule

// File: tb/tb_ddr3_byte_packer.sv
// Directed bench for ddr3_byte_packer with OUT_BYTES=4. A per-cycle task samples outputs on the
// falling edge, then drives the FIFO model and out_ready just after the rising edge.

module tb_ddr3_byte_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         xfer_start = 1'b0;
  logic [31:0]  xfer_byte_num = '0;
  logic         busy;
  logic         xfer_done;
  logic         overflow_err;
  logic         fifo_data_ready_in = 1'b0;
  logic         fifo_read_req_out;
  logic [287:0] fifo_read_data_in = '0;
  logic         fifo_read_data_valid_in = 1'b0;
  logic [31:0]  out_data;
  logic [3:0]   out_keep;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;

  ddr3_byte_packer #(
    .OUT_BYTES (4),
    .CNT_W     (32)
  ) u_dut (
    .ddr3_emif_clk           (clk),
    .ddr3_emif_rst           (rst),
    .xfer_start              (xfer_start),
    .xfer_byte_num           (xfer_byte_num),
    .busy                    (busy),
    .xfer_done               (xfer_done),
    .overflow_err            (overflow_err),
    .fifo_data_ready_in      (fifo_data_ready_in),
    .fifo_read_req_out       (fifo_read_req_out),
    .fifo_read_data_in       (fifo_read_data_in),
    .fifo_read_data_valid_in (fifo_read_data_valid_in),
    .out_data                (out_data),
    .out_keep                (out_keep),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .out_last                (out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [287:0] fifo_q [$];
  logic [31:0]  got_data [$];
  logic [3:0]   got_keep [$];
  logic         got_last [$];
  logic [31:0]  exp_data [$];
  logic [3:0]   exp_keep [$];
  logic         exp_last [$];

  int    done_cnt = 0;
  int    valid_cnt = 0;
  int    stab_err = 0;
  int    req_err = 0;
  logic  hold_pend = 1'b0;
  logic [31:0] h_data = '0;
  logic [3:0]  h_keep = '0;
  logic        h_last = 1'b0;
  logic  req_seen = 1'b0;
  logic  stall = 1'b0;
  logic  rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [287:0] mk(input logic [7:0] b0, input logic [31:0] m);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[255-8*i -: 8] = b0 + 8'(i);
    return {d, m};
  endfunction

  function automatic logic [31:0] w4(input int b);
    return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
  endfunction

  task automatic exp_push(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_data.push_back(d);
    exp_keep.push_back(k);
    exp_last.push_back(l);
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic tick();
    @(negedge clk);
    if (xfer_done) done_cnt++;
    if (out_valid) valid_cnt++;
    if (fifo_read_req_out && ((out_valid && out_keep == 4'hf) || !fifo_data_ready_in)) req_err++;
    if (hold_pend && (!out_valid || out_data !== h_data || out_keep !== h_keep ||
                      out_last !== h_last)) stab_err++;
    hold_pend = out_valid && !out_ready && !rst;
    h_data = out_data;
    h_keep = out_keep;
    h_last = out_last;
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_keep.push_back(out_keep);
      got_last.push_back(out_last);
    end
    req_seen = fifo_read_req_out;
    @(posedge clk);
    #1;
    if (req_seen && fifo_q.size() != 0) begin
      fifo_read_data_in = fifo_q.pop_front();
      fifo_read_data_valid_in = 1'b1;
    end else begin
      fifo_read_data_valid_in = 1'b0;
    end
    fifo_data_ready_in = (fifo_q.size() != 0) && !stall;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic start_xfer(input logic [31:0] num);
    xfer_byte_num = num;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    repeat (2) tick();
    chk(tag, 64'(done_cnt), 64'd1);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_count"}, 64'(got_data.size()), 64'(exp_data.size()));
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
      chk($sformatf("%s_keep%0d", tag, i), 64'(got_keep[i]), 64'(exp_keep[i]));
      chk($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(exp_last[i]));
    end
    got_data.delete(); got_keep.delete(); got_last.delete();
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(xfer_done), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow_err), 64'd0);
    chk({tag, "_req"}, 64'(fifo_read_req_out), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_keep"}, 64'(out_keep), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: two full words, bytes 0x00..0x3f
    fifo_q.push_back(mk(8'h00, 32'hffffffff));
    fifo_q.push_back(mk(8'h20, 32'hffffffff));
    for (int w = 0; w < 16; w++) exp_push(w4(4 * w), 4'hf, w == 15);
    done_cnt = 0;
    start_xfer(64);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_xfer_done", 300);
    compare_stream("t1");
    chk("t1_ovf", 64'(overflow_err), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // 2: leading gap, full word, trailing run
    fifo_q.push_back(mk(8'h00, 32'h1fffffff));
    fifo_q.push_back(mk(8'h20, 32'hffffffff));
    fifo_q.push_back(mk(8'h40, 32'he0000000));
    for (int w = 0; w < 16; w++) exp_push(w4(3 + 4 * w), 4'hf, w == 15);
    done_cnt = 0;
    start_xfer(64);
    wait_done("t2_xfer_done", 300);
    compare_stream("t2");
    chk("t2_ovf", 64'(overflow_err), 64'd0);

    // 3: six bytes -> full word then partial last word; a start while busy is ignored
    fifo_q.push_back(mk(8'h00, 32'hfc000000));
    exp_push(32'h00010203, 4'hf, 1'b0);
    exp_push(32'h04050000, 4'hc, 1'b1);
    done_cnt = 0;
    start_xfer(6);
    start_xfer(64);
    wait_done("t3_xfer_done", 100);
    compare_stream("t3");
    chk("t3_ovf", 64'(overflow_err), 64'd0);

    // 4: same output, excess valid bytes raise overflow_err
    fifo_q.push_back(mk(8'h00, 32'hffffffff));
    exp_push(32'h00010203, 4'hf, 1'b0);
    exp_push(32'h04050000, 4'hc, 1'b1);
    done_cnt = 0;
    start_xfer(6);
    wait_done("t4_xfer_done", 100);
    compare_stream("t4");
    chk("t4_ovf", 64'(overflow_err), 64'd1);

    // 5: random out_ready and a 20-cycle FIFO-empty stall
    fifo_q.push_back(mk(8'h00, 32'hffffffff));
    fifo_q.push_back(mk(8'h20, 32'hffffffff));
    fifo_q.push_back(mk(8'h40, 32'hffffffff));
    for (int w = 0; w < 24; w++) exp_push(w4(4 * w), 4'hf, w == 23);
    rand_rdy = 1'b1;
    done_cnt = 0;
    start_xfer(96);
    repeat (4) tick();
    stall = 1'b1;
    repeat (20) tick();
    stall = 1'b0;
    wait_done("t5_xfer_done", 600);
    rand_rdy = 1'b0;
    tick();
    compare_stream("t5");
    chk("t5_stable", 64'(stab_err), 64'd0);
    chk("t5_req_rules", 64'(req_err), 64'd0);
    chk("t5_ovf_sticky", 64'(overflow_err), 64'd1);

    // 6: reset mid-transfer, then an empty transfer, then a normal one
    fifo_q.push_back(mk(8'h00, 32'hffffffff));
    fifo_q.push_back(mk(8'h20, 32'hffffffff));
    start_xfer(64);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("t6_rst");
    fifo_q.delete();
    tick();
    got_data.delete(); got_keep.delete(); got_last.delete();
    done_cnt = 0;
    valid_cnt = 0;
    start_xfer(0);
    wait_done("t6_zero_done", 20);
    chk("t6_zero_novalid", 64'(valid_cnt), 64'd0);
    fifo_q.push_back(mk(8'h00, 32'hfc000000));
    exp_push(32'h00010203, 4'hf, 1'b0);
    exp_push(32'h04050000, 4'hc, 1'b1);
    done_cnt = 0;
    start_xfer(6);
    wait_done("t6_xfer_done", 100);
    compare_stream("t6");
    chk("t6_ovf", 64'(overflow_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
